// File: rtl/updown_counter.sv
// Up/down modulo counter: runtime limit, sync clear/load, wrap or saturate, terminal-count pulse.
// Latency: o_value/o_tc registered, one edge after inputs sampled; o_zero/o_at_limit follow o_value.
// Backpressure: none; i_en is a plain enable and the block is always ready.
//
// Ports:
//   i_clk, i_a_rst_n   clock (rising edge) and asynchronous active-low reset
//   i_clr              synchronous clear to RST_VALUE (highest priority)
//   i_load             synchronous load of min(i_load_value, limit)
//   i_en, i_dir        count enable, direction (1 = up, 0 = down)
//   i_limit            runtime terminal value, clamped to MAX_VALUE
//   o_value, o_tc      registered count and one-cycle terminal-count pulse
//   o_zero, o_at_limit flags decoded from the count register
//   o_tick             (UPDOWN_COUNTER_PRESCALER_EN only) one-cycle pulse per prescaled step
//
// Optional feature macro: UPDOWN_COUNTER_PRESCALER_EN adds parameter PRESCALE and port o_tick.
// With it, only every PRESCALE-th enabled cycle is a count step.

module updown_counter #(
    parameter int MAX_VALUE = 8,
    parameter bit SATURATE  = 1'b0,
    parameter int RST_VALUE = 0
`ifdef UPDOWN_COUNTER_PRESCALER_EN
    ,
    parameter int PRESCALE  = 4
`endif
    ,
    localparam int WIDTH    = $clog2(MAX_VALUE + 1)
) (
    input  logic             i_clk,
    input  logic             i_a_rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_en,
    input  logic             i_dir,
    input  logic [WIDTH-1:0] i_limit,
    output logic [WIDTH-1:0] o_value,
    output logic             o_tc,
    output logic             o_zero,
    output logic             o_at_limit
`ifdef UPDOWN_COUNTER_PRESCALER_EN
    ,
    output logic             o_tick
`endif
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (MAX_VALUE < 1) begin : g_bad_max
        $error("updown_counter: MAX_VALUE must be >= 1");
    end

    if (RST_VALUE < 0 || RST_VALUE > MAX_VALUE) begin : g_bad_rst
        $error("updown_counter: RST_VALUE must lie in 0..MAX_VALUE");
    end

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VALUE);

    // ------------------------------------------------------------------
    // Effective limit, re-evaluated every cycle with no shadow register
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] lim;

    assign lim = (i_limit > MAX_W) ? MAX_W : i_limit;

    // ------------------------------------------------------------------
    // Step qualification: either every enabled cycle, or one in PRESCALE
    // ------------------------------------------------------------------
    logic step;

`ifdef UPDOWN_COUNTER_PRESCALER_EN
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("updown_counter: PRESCALE must be >= 1");
    end

    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          tick_q;
    logic          tick_d;

    // Clear and load restart the spacing so the first step after them is
    // always a full PRESCALE enabled cycles away.
    always_comb begin
        pre_d  = pre_q;
        tick_d = 1'b0;
        step   = 1'b0;
        if (i_clr || i_load) begin
            pre_d = '0;
        end else if (i_en) begin
            if (pre_q == PRE_LAST) begin
                pre_d  = '0;
                step   = 1'b1;
                tick_d = 1'b1;
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    assign o_tick = tick_q;
`else
    assign step = i_en;
`endif

    // ------------------------------------------------------------------
    // Count next-state
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic             tc_q;
    logic             tc_d;

    always_comb begin
        value_d = value_q;
        tc_d    = 1'b0;
        if (i_clr) begin
            value_d = RST_W;
        end else if (i_load) begin
            value_d = (i_load_value > lim) ? lim : i_load_value;
        end else if (step) begin
            if (value_q > lim) begin
                // Limit dropped below the current count: snap onto it
                // without signalling a terminal count.
                value_d = lim;
            end else if (i_dir) begin
                if (value_q == lim) begin
                    value_d = SATURATE ? lim : '0;
                    tc_d    = 1'b1;
                end else begin
                    value_d = value_q + WIDTH'(1);
                end
            end else begin
                if (value_q == '0) begin
                    value_d = SATURATE ? '0 : lim;
                    tc_d    = 1'b1;
                end else begin
                    value_d = value_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) begin
            value_q <= RST_W;
            tc_q    <= 1'b0;
        end else begin
            value_q <= value_d;
            tc_q    <= tc_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_value    = value_q;
    assign o_tc       = tc_q;
    assign o_zero     = (value_q == '0);
    assign o_at_limit = (value_q == lim);

endmodule
